// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, request type and helpers for the writeback arbiter
//
// IDX_W_DEF / WIDTH_DEF : default register index and data widths
// wb_req_t              : {rd, data} pair carried through the load FIFO
// onehot_rd()           : register index -> one-hot register mask
package wb_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int WIDTH_DEF = 32;
    localparam int NREG_DEF  = 2 ** IDX_W_DEF;

    // The struct is sized from the package defaults, so the arbiter and the
    // FIFO are built for IDX_W_DEF / WIDTH_DEF.
    typedef struct packed {
        logic [IDX_W_DEF-1:0] rd;
        logic [WIDTH_DEF-1:0] data;
    } wb_req_t;

    function automatic logic [NREG_DEF-1:0] onehot_rd(input logic [IDX_W_DEF-1:0] rd);
        logic [NREG_DEF-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: ALU/load inputs, bank write port, pending mask
//
// alu_valid/alu_rd/alu_data   : ALU result, always accepted
// mem_valid/mem_ready/mem_rd/mem_data : load result handshake
// we/rd/wd                    : registered register-bank write port
// pending_mask                : registers with a write still in flight
// stat_writes/stat_mem_stalls : counters, present only with WB_STATS_EN
// Modports: slave = arbiter side, master = producer/bank side.
interface wb_arbiter_if import wb_pkg::*; #(
    parameter int IDX_W = IDX_W_DEF,
    parameter int WIDTH = WIDTH_DEF
) ();

    logic                  alu_valid;
    logic [IDX_W-1:0]      alu_rd;
    logic [WIDTH-1:0]      alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [IDX_W-1:0]      mem_rd;
    logic [WIDTH-1:0]      mem_data;
    logic                  we;
    logic [IDX_W-1:0]      rd;
    logic [WIDTH-1:0]      wd;
    logic [2**IDX_W-1:0]   pending_mask;
`ifdef WB_STATS_EN
    logic [31:0]           stat_writes;
    logic [31:0]           stat_mem_stalls;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
`ifdef WB_STATS_EN
        output stat_writes, stat_mem_stalls,
`endif
        output mem_ready, we, rd, wd, pending_mask
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
`ifdef WB_STATS_EN
        input  stat_writes, stat_mem_stalls,
`endif
        input  mem_ready, we, rd, wd, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load result FIFO with per-entry valid vector
//
// clk, rst        : clock, asynchronous active-high reset
// i_push/i_push_req : enqueue one request at the tail (ignored when full)
// i_pop           : dequeue the head (ignored when empty)
// o_head          : request at the head
// o_full/o_empty  : occupancy flags from the registered count
// o_valid/o_entries : per-slot valid bit and contents, for the pending mask
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wb_req_t i_push_req,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty,
    output logic [DEPTH-1:0] o_valid,
    output wb_req_t o_entries [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_off;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_head];
    assign o_entries = r_mem;

    // Pointers are DEPTH-wide modulo counters; DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + PTR_W'(1);
            if (w_do_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail] <= i_push_req;
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        w_off   = '0;
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PTR_W'(i) - r_head;
            o_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and load results onto one bank write port
//
// clk, rst : clock, asynchronous active-high reset
// bus      : wb_arbiter_if.slave (ALU input, load handshake, bank write port, pending mask)
// Optional macro WB_STATS_EN adds stat_writes / stat_mem_stalls counters on bus.
module wb_arbiter import wb_pkg::*; #(
    parameter int IDX_W = IDX_W_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    localparam int NREG = 2 ** IDX_W;

    logic             r_we;
    logic [IDX_W-1:0] r_rd;
    logic [WIDTH-1:0] r_wd;

    logic             w_alu_take;
    logic             w_mem_fire;
    logic             w_mem_keep;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    wb_req_t          w_head;
    wb_req_t          w_push_req;
    logic [DEPTH-1:0] w_valid;
    wb_req_t          w_entries [DEPTH];
    logic [NREG-1:0]  w_mask;

    // Writes to register 0 are accepted but never reach the bank or the FIFO.
    assign w_alu_take = bus.alu_valid && (bus.alu_rd != '0);
    assign w_mem_fire = bus.mem_valid && !w_full;
    assign w_mem_keep = w_mem_fire && (bus.mem_rd != '0);
    assign w_pop      = !w_alu_take && !w_empty;
    // Bypass only when nothing older is queued, so loads never reorder.
    assign w_bypass   = !w_alu_take && w_empty && w_mem_keep;
    assign w_push     = w_mem_keep && !w_bypass;
    assign w_push_req = '{rd: bus.mem_rd, data: bus.mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_req (w_push_req),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_valid    (w_valid),
        .o_entries  (w_entries)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we <= 1'b0;
            r_rd <= '0;
            r_wd <= '0;
        end else begin
            r_we <= w_alu_take || w_pop || w_bypass;
            if (w_alu_take) begin
                r_rd <= bus.alu_rd;
                r_wd <= bus.alu_data;
            end else if (w_pop) begin
                r_rd <= w_head.rd;
                r_wd <= w_head.data;
            end else if (w_bypass) begin
                r_rd <= bus.mem_rd;
                r_wd <= bus.mem_data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_mask = w_mask | onehot_rd(w_entries[i].rd);
        end
        if (r_we) w_mask = w_mask | onehot_rd(r_rd);
        w_mask[0] = 1'b0;
    end

    // Ready depends on registered occupancy only: no pass-through when full.
    assign bus.mem_ready    = !w_full;
    assign bus.we           = r_we;
    assign bus.rd           = r_rd;
    assign bus.wd           = r_wd;
    assign bus.pending_mask = w_mask;

`ifdef WB_STATS_EN
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_mem_stalls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_writes     <= '0;
            r_stat_mem_stalls <= '0;
        end else begin
            if (r_we) r_stat_writes <= r_stat_writes + 32'd1;
            if (bus.mem_valid && !bus.mem_ready) r_stat_mem_stalls <= r_stat_mem_stalls + 32'd1;
        end
    end

    assign bus.stat_writes     = r_stat_writes;
    assign bus.stat_mem_stalls = r_stat_mem_stalls;
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register bank. It merges results from the ALU and the data-memory load path onto the bank's single write port (we/rd/wd).
- ALU results have priority. Load results are buffered in a small FIFO and drained on cycles when the ALU is idle.
- It exports a pending-write mask so decode can stall on registers that still have a result in flight.

Parameters:
- IDX_W, 4, register index width (2**IDX_W architectural registers).
- WIDTH, 32, data width.
- DEPTH, 4, load FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result valid this cycle; always accepted.
- alu_rd  in  IDX_W  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when mem_valid and mem_ready are both 1.
- mem_rd  in  IDX_W  load destination register.
- mem_data  in  WIDTH  load result.
- we  out  1  register-bank write enable (registered).
- rd  out  IDX_W  register-bank write index (registered).
- wd  out  WIDTH  register-bank write data (registered).
- pending_mask  out  2**IDX_W  bit i set when register i has a write queued in the FIFO or held in the output register.

Behaviour:
- Reset (async, any time, including mid-drain):
  - we=0, rd=0, wd=0.
  - FIFO emptied: head=tail=count=0.
  - pending_mask=0, mem_ready=1 once rst deasserts.
  - In-flight data is discarded.
- Output register: one write per cycle at most. we/rd/wd are loaded on posedge and held for exactly one cycle. The bank samples them on the following negedge.
- Per-cycle selection, in priority order:
  1. alu_valid=1 and alu_rd!=0: output is loaded with the ALU result.
  2. Otherwise, FIFO not empty: output is loaded from the FIFO head, and the head is popped.
  3. Otherwise, a load handshake fires with mem_rd!=0: the load bypasses the FIFO and loads the output directly.
  4. Otherwise: we=0, and rd/wd hold their previous values.
- Load enqueue: a handshaking load that is not bypassed by rule 3 is pushed at the tail.
- Simultaneous push and pop: allowed in the same cycle; count is unchanged.
- Latency:
  - ALU: 1 cycle (we high in the cycle after alu_valid).
  - Load, FIFO empty and ALU idle: 1 cycle.
  - Load, otherwise: 1 cycle plus queue wait.
- Ordering: loads retire in FIFO order. No load is ever overtaken by a later load.
- mem_ready = (count != DEPTH), derived from registered count only. There is no pass-through when full, even if a pop occurs in that cycle.
- Register 0: a result with destination 0 is accepted and dropped. It never sets we, is never enqueued, and never sets pending_mask bit 0. pending_mask bit 0 is constant 0.
- pending_mask: combinational OR of the one-hot rd of each valid FIFO entry, plus the output register's rd when we=1. Multiple entries for the same rd keep the bit set until all of them have retired.
- FIFO pointers are IDX-free, log2(DEPTH) bits wide, and wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- Bounded starvation is not provided: a continuous ALU stream starves the FIFO. Upstream issue logic must guarantee idle slots.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - Adds outputs stat_writes (32) and stat_mem_stalls (32).
  - stat_writes increments on every cycle with we=1.
  - stat_mem_stalls increments on every cycle with mem_valid=1 and mem_ready=0.
  - Both counters wrap at 2**32 and are cleared by rst.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package wb_pkg:
  - constants IDX_W_DEF, WIDTH_DEF.
  - typedef wb_req_t {rd, data}.
  - function onehot_rd(rd).
- One sub-module is natural: wb_fifo (DEPTH entries of wb_req_t, push/pop/full/empty, per-entry valid vector exported for the mask).

Test Plan:
- Reset mid-drain: FIFO holds 3 loads, assert rst → we=0, pending_mask=0, mem_ready=1 after release, and none of the 3 loads is ever written.
- Bypass: idle, mem_valid with rd=5, data=0xDEADBEEF → next cycle we=1, rd=5, wd=0xDEADBEEF. The FIFO stays empty.
- Priority: same cycle alu(rd=3, 0x11) and mem(rd=4, 0x22) →
  - cycle+1: rd=3, wd=0x11.
  - cycle+2: rd=4, wd=0x22.
  - pending_mask bit 4 is set from cycle+1 through cycle+2.
- Full FIFO: alu_valid held high while 4 loads (rd=1..4) arrive → mem_ready=0 on the 5th offer, stat_mem_stalls increments. After the ALU drops, writes rd=1,2,3,4 occur in order on consecutive cycles.
- Register 0: alu_rd=0 and mem_rd=0 both offered → we stays 0, mem_ready stays 1, pending_mask=0.
- Duplicate rd: two loads to rd=7 queued → bit 7 stays set until the second write retires, and the final value equals the second load's data.
